// File: rtl/earom_upload.sv
// Streams the EAROM shadow image back to the HPS over the ioctl upload channel,
// holding the game CPU paused while the upload is active.
module earom_upload #(
    parameter logic [7:0] INDEX       = 8'd4,
    parameter int         ADDR_W      = 6,
    parameter int         DEPTH       = 64,
    parameter int         RAM_LATENCY = 2,
    parameter int         SETTLE      = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_o,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_dout,
    output logic              active_o
);

    localparam int          CW          = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [2:0]  LAT_LAST    = 3'(RAM_LATENCY);
    localparam logic [24:0] DEPTH_A     = 25'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETTLE_S, READY, FETCH} state_t;

    state_t              state_q, state_d;
    logic                upload_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          lat_q, lat_d;
    logic                pend_q, pend_d;
    logic                pend_ok_q, pend_ok_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [7:0]          din_q, din_d;
    logic                wait_q, wait_d;
    logic                pause_q, pause_d;
    logic                active_q, active_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_rd_q, ram_rd_d;

    logic                in_range;
    logic                rd_pend, rd_ok;
    logic [ADDR_W-1:0]   rd_addr;

    assign in_range = (ioctl_addr < DEPTH_A);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            upload_q    <= 1'b0;
            cnt_q       <= '0;
            lat_q       <= '0;
            pend_q      <= 1'b0;
            pend_ok_q   <= 1'b0;
            pend_addr_q <= '0;
            din_q       <= 8'hFF;
            wait_q      <= 1'b0;
            pause_q     <= 1'b0;
            active_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            upload_q    <= ioctl_upload;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            pend_q      <= pend_d;
            pend_ok_q   <= pend_ok_d;
            pend_addr_q <= pend_addr_d;
            din_q       <= din_d;
            wait_q      <= wait_d;
            pause_q     <= pause_d;
            active_q    <= active_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_q    <= ram_rd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        pend_d      = pend_q;
        pend_ok_d   = pend_ok_q;
        pend_addr_d = pend_addr_q;
        din_d       = din_q;
        wait_d      = wait_q;
        pause_d     = pause_q;
        active_d    = active_q;
        ram_addr_d  = ram_addr_q;
        ram_rd_d    = 1'b0;
        rd_pend     = pend_q;
        rd_ok       = pend_ok_q;
        rd_addr     = pend_addr_q;

        if (!ioctl_upload) begin
            // Upload end abandons any in-flight fetch; ioctl_din keeps its last value.
            state_d  = IDLE;
            wait_d   = 1'b0;
            pause_d  = 1'b0;
            active_d = 1'b0;
            pend_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!upload_q && ioctl_index == INDEX) begin
                        state_d  = SETTLE_S;
                        cnt_d    = '0;
                        pend_d   = 1'b0;
                        pause_d  = 1'b1;
                        active_d = 1'b1;
                        wait_d   = 1'b1;
                    end
                end
                SETTLE_S: begin
                    // The HPS may ignore wait here; hold one early read for READY entry.
                    if (ioctl_rd && !pend_q) begin
                        rd_pend = 1'b1;
                        rd_ok   = in_range;
                        rd_addr = ioctl_addr[ADDR_W-1:0];
                    end
                    pend_d      = rd_pend;
                    pend_ok_d   = rd_ok;
                    pend_addr_d = rd_addr;
                    if (cnt_q == SETTLE_LAST) begin
                        pend_d = 1'b0;
                        if (rd_pend && rd_ok) begin
                            state_d    = FETCH;
                            ram_rd_d   = 1'b1;
                            ram_addr_d = rd_addr;
                            lat_d      = '0;
                        end else begin
                            state_d = READY;
                            wait_d  = 1'b0;
                            if (rd_pend) din_d = 8'hFF;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: begin
                    if (ioctl_rd) begin
                        if (in_range) begin
                            state_d    = FETCH;
                            ram_rd_d   = 1'b1;
                            ram_addr_d = ioctl_addr[ADDR_W-1:0];
                            wait_d     = 1'b1;
                            lat_d      = '0;
                        end else begin
                            din_d = 8'hFF;
                        end
                    end
                end
                FETCH: begin
                    if (lat_q == LAT_LAST) begin
                        din_d   = ram_dout;
                        wait_d  = 1'b0;
                        state_d = READY;
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign pause_o    = pause_q;
    assign active_o   = active_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;

endmodule

// File: tb/tb_earom_upload.sv
// Directed bench for earom_upload: reset, full image upload, foreign index,
// out-of-range reads, abandoned fetch, early read during settle, async reset.
module tb_earom_upload;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_o;
    logic [5:0]  ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_dout;
    logic        active_o;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int base;
    int k;

    always #5 clk_sys = ~clk_sys;

    earom_upload dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .pause_o(pause_o),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_dout(ram_dout), .active_o(active_o)
    );

    // Two-cycle RAM: data for a strobed address appears two cycles later, zero otherwise.
    logic [7:0] p0, p1;
    always @(posedge clk_sys) begin
        p0 <= (ram_rd === 1'b1) ? ({2'b00, ram_addr} ^ 8'hA5) : 8'h00;
        p1 <= p0;
        if (ram_rd === 1'b1) rd_cnt <= rd_cnt + 1;
    end
    assign ram_dout = p1;

    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_upload(input logic [7:0] idx);
        ioctl_index  = idx;
        ioctl_upload = 1'b1;
        step;
    endtask

    task automatic end_upload;
        ioctl_upload = 1'b0;
        step;
        chk("end_pause", 32'(pause_o), 32'd0);
        chk("end_active", 32'(active_o), 32'd0);
        chk("end_wait", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic do_read(input logic [24:0] a, input logic [7:0] exp);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        step;
        ioctl_rd = 1'b0;
        chk("rd_strobe", 32'(ram_rd), 32'd1);
        chk("rd_addr", 32'(ram_addr), 32'(a[5:0]));
        chk("rd_wait_hi", 32'(ioctl_wait), 32'd1);
        step;
        chk("rd_strobe_1cyc", 32'(ram_rd), 32'd0);
        step;
        chk("rd_wait_lat", 32'(ioctl_wait), 32'd1);
        step;
        chk("rd_wait_lo", 32'(ioctl_wait), 32'd0);
        chk("rd_data", 32'(ioctl_din), 32'(exp));
    endtask

    initial begin
        reset_n = 1'b0; ioctl_upload = 1'b1; ioctl_index = 8'd4;
        ioctl_rd = 1'b0; ioctl_addr = '0;
        // 1: reset held while an upload is requested
        repeat (4) step;
        chk("rst_din", 32'(ioctl_din), 32'hFF);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_pause", 32'(pause_o), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_ramrd", 32'(ram_rd), 32'd0);
        chk("rst_active", 32'(active_o), 32'd0);
        chk("rst_rdcnt", 32'(rd_cnt), 32'd0);
        ioctl_upload = 1'b0;
        step;
        reset_n = 1'b1;
        repeat (2) step;

        // 2: full image upload on index 4
        start_upload(8'd4);
        chk("acc_pause", 32'(pause_o), 32'd1);
        chk("acc_active", 32'(active_o), 32'd1);
        chk("acc_wait", 32'(ioctl_wait), 32'd1);
        repeat (15) step;
        chk("settle_wait_hi", 32'(ioctl_wait), 32'd1);
        step;
        chk("settle_wait_lo", 32'(ioctl_wait), 32'd0);
        base = rd_cnt;
        for (int a = 0; a < 64; a++) do_read(25'(a), 8'(a) ^ 8'hA5);
        chk("img_rdcnt", 32'(rd_cnt - base), 32'd64);

        // 4: out-of-range reads and a read issued during FETCH
        base = rd_cnt;
        ioctl_rd = 1'b1; ioctl_addr = 25'd64;
        step;
        ioctl_rd = 1'b0;
        chk("oor64_din", 32'(ioctl_din), 32'hFF);
        chk("oor64_wait", 32'(ioctl_wait), 32'd0);
        chk("oor64_ramrd", 32'(ram_rd), 32'd0);
        ioctl_rd = 1'b1; ioctl_addr = 25'd7;
        step;
        ioctl_addr = 25'd9;
        step;
        ioctl_rd = 1'b0;
        step;
        step;
        chk("viol_din", 32'(ioctl_din), 32'hA2);
        ioctl_rd = 1'b1; ioctl_addr = 25'h100000;
        step;
        ioctl_rd = 1'b0;
        chk("oorhi_din", 32'(ioctl_din), 32'hFF);
        chk("oorhi_wait", 32'(ioctl_wait), 32'd0);
        step;
        chk("oor_rdcnt", 32'(rd_cnt - base), 32'd1);
        end_upload;

        // 3: foreign index is ignored entirely
        base = rd_cnt;
        start_upload(8'd0);
        chk("idx0_pause", 32'(pause_o), 32'd0);
        chk("idx0_active", 32'(active_o), 32'd0);
        chk("idx0_wait", 32'(ioctl_wait), 32'd0);
        for (int i = 0; i < 6; i++) begin
            ioctl_rd = 1'b1; ioctl_addr = 25'(i);
            step;
            ioctl_rd = 1'b0;
            repeat (4) step;
        end
        chk("idx0_pause_late", 32'(pause_o), 32'd0);
        chk("idx0_rdcnt", 32'(rd_cnt - base), 32'd0);
        chk("idx0_din", 32'(ioctl_din), 32'hFF);
        ioctl_upload = 1'b0;
        step;

        // 5: upload dropped one cycle after the RAM strobe
        start_upload(8'd4);
        repeat (16) step;
        ioctl_rd = 1'b1; ioctl_addr = 25'd5;
        step;
        ioctl_rd = 1'b0;
        chk("drop_ramrd", 32'(ram_rd), 32'd1);
        end_upload;
        repeat (4) step;
        chk("drop_nocapture", 32'(ioctl_din), 32'hFF);
        start_upload(8'd4);
        repeat (16) step;
        do_read(25'd5, 8'hA0);
        end_upload;

        // 6: read issued 3 cycles after accept is served at end of settle
        start_upload(8'd4);
        repeat (2) step;
        ioctl_rd = 1'b1; ioctl_addr = 25'd12;
        step;
        ioctl_rd = 1'b0;
        k = 3;
        while (ram_rd !== 1'b1 && k < 40) begin
            step;
            k++;
        end
        chk("early_rd_time", 32'(k), 32'd16);
        chk("early_rd_addr", 32'(ram_addr), 32'd12);
        repeat (3) step;
        chk("early_rd_data", 32'(ioctl_din), 32'hA9);
        chk("early_rd_wait", 32'(ioctl_wait), 32'd0);

        // Async reset mid-upload clears outputs without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pause", 32'(pause_o), 32'd0);
        chk("arst_active", 32'(active_o), 32'd0);
        chk("arst_din", 32'(ioctl_din), 32'hFF);
        ioctl_upload = 1'b0;
        step;
        reset_n = 1'b1;
        step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
